// File: rtl/seg7_pkg.sv
// Shared segment codes for the 7-segment scan driver (active-low {g,f,e,d,c,b,a}).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0 is the rightmost entry: 0..9, A, b, C, d, E, F.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern; non-decimal nibbles show a dash in BCD mode.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  // Table lookup, overridden by the dash for invalid BCD values.
  always_comb begin
    o_seg = SEG_HEX[i_nibble];
    if (!i_hex_mode && (i_nibble > 4'd9)) begin
      o_seg = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-frame digit snapshot,
// anti-ghost blanking, leading-zero suppression, decimal points and digit masks.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clkSignal,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    hex_mode,
  input  logic                    lzs_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(REFRESH_DIV - 1);
  localparam logic [DivW-1:0] BlankEnd = DivW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  logic [DivW-1:0]                 r_div_cnt;
  logic [IdxW-1:0]                 r_idx;
  logic [NUM_DIGITS-1:0][3:0]      r_snap;
  logic [NUM_DIGITS-1:0]           r_an;
  logic [6:0]                      r_seg;
  logic                            r_dp;
  logic                            r_frame_done;

  logic                            w_frame_start;
  logic [NUM_DIGITS-1:0]           w_upper_zero;
  logic                            w_dark;
  logic                            w_lit;
  logic [6:0]                      w_seg;
  logic [NUM_DIGITS-1:0]           w_an_d;
  logic [6:0]                      w_seg_d;
  logic                            w_dp_d;
  logic                            w_frame_done_d;

  assign w_frame_start = (r_idx == '0) && (r_div_cnt == '0);

  // Slot timer and digit index; idx wraps explicitly so non-power-of-2 counts work.
  always_ff @(posedge clkSignal or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (r_div_cnt == DivLast) begin
      r_div_cnt <= '0;
      r_idx     <= (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DivW'(1);
    end
  end

  // Snapshot digits once per frame so a frame never mixes old and new values.
  always_ff @(posedge clkSignal or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (w_frame_start) begin
      r_snap <= digits;
    end
  end

  // w_upper_zero[i]: snapshot digits i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic v_zero;
    v_zero       = 1'b1;
    w_upper_zero = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      v_zero          = v_zero & (r_snap[i] == 4'h0);
      w_upper_zero[i] = v_zero;
    end
  end

  assign w_dark = blank_mask[r_idx] | (lzs_en & (r_idx != '0) & w_upper_zero[r_idx]);
  assign w_lit  = (r_div_cnt >= BlankEnd) & ~w_dark;

  seg7_decode u_decode (
    .i_nibble   (r_snap[r_idx]),
    .i_hex_mode (hex_mode),
    .o_seg      (w_seg)
  );

  // Next output values: dark by default, one anode low during a lit phase.
  always_comb begin
    w_an_d  = '1;
    w_seg_d = SEG_BLANK;
    w_dp_d  = 1'b1;
    if (w_lit) begin
      w_an_d[r_idx] = 1'b0;
      w_seg_d       = w_seg;
      w_dp_d        = ~dp_mask[r_idx];
    end
    w_frame_done_d = (r_idx == IdxLast) && (r_div_cnt == DivLast);
  end

  // Registered pin drivers; reset forces the display dark immediately.
  always_ff @(posedge clkSignal or negedge rst) begin
    if (!rst) begin
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_d;
      r_seg        <= w_seg_d;
      r_dp         <= w_dp_d;
      r_frame_done <= w_frame_done_d;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
